// File: rtl/fp_addsub_unit_if.sv
// Operand/result bundle for fp_addsub_unit: request, operands, result, flags and idle.
// The master drives requests; the slave (the adder) returns results.
interface fp_addsub_if #(
    parameter int EXP_W = 7,
    parameter int MAN_W = 15
);
    logic             op_valid;
    logic             op_sub;
    logic             a_s;
    logic [EXP_W-1:0] a_e;
    logic [MAN_W-1:0] a_m;
    logic             b_s;
    logic [EXP_W-1:0] b_e;
    logic [MAN_W-1:0] b_m;
    logic             res_s;
    logic [EXP_W-1:0] res_e;
    logic [MAN_W-1:0] res_m;
    logic             res_valid;
    logic             ovf;
    logic             unf;
    logic             idle;

    modport master (
        output op_valid, op_sub, a_s, a_e, a_m, b_s, b_e, b_m,
        input  res_s, res_e, res_m, res_valid, ovf, unf, idle
    );

    modport slave (
        input  op_valid, op_sub, a_s, a_e, a_m, b_s, b_e, b_m,
        output res_s, res_e, res_m, res_valid, ovf, unf, idle
    );
endinterface

// File: rtl/fp_addsub_unit.sv
// Sign/magnitude float add/sub, fixed-latency FSM: ALIGN, SHIFT, ADDSUB, NORM, DONE.
// Define FP_ADDSUB_ROUND_EN to insert a ROUND state (nearest, ties away from zero).
module fp_addsub_unit #(
    parameter int EXP_W = 7,
    parameter int MAN_W = 15
) (
    input  logic         clk,
    input  logic         reset,
    fp_addsub_if.slave   bus
);
    localparam int LZ_W  = $clog2(MAN_W + 1);
    localparam int RES_W = EXP_W + MAN_W + 3;
    localparam logic signed [EXP_W+1:0] E_MAX  = $signed({3'b000, {(EXP_W-1){1'b1}}});
    localparam logic signed [EXP_W+1:0] E_MIN  = $signed({3'b111, {(EXP_W-1){1'b0}}});
    localparam logic signed [EXP_W+1:0] E_ONE  = $signed({{(EXP_W+1){1'b0}}, 1'b1});
    localparam logic [EXP_W-1:0]        E_ZERO = {1'b1, {(EXP_W-1){1'b0}}};
    localparam logic [EXP_W-1:0]        E_TOP  = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W:0]          SH_LIM = (EXP_W+1)'(MAN_W + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_SHIFT  = 3'd2,
        S_ADDSUB = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Result packing {ovf, unf, s, e, m} with zero, overflow saturation and underflow flush.
    function automatic logic [RES_W-1:0] pack_result(input logic s,
                                                     input logic signed [EXP_W+1:0] e,
                                                     input logic [MAN_W-1:0] m,
                                                     input logic z);
        logic [RES_W-1:0] r;
        if (z) begin
            r = {RES_W{1'b0}};
        end else if (e > E_MAX) begin
            r = {1'b1, 1'b0, s, E_TOP, {MAN_W{1'b1}}};
        end else if (e < E_MIN) begin
            r = {1'b0, 1'b1, {(RES_W-2){1'b0}}};
        end else begin
            r = {2'b00, s, e[EXP_W-1:0], m};
        end
        return r;
    endfunction

    state_t                   state_q;
    logic                     idle_q, res_valid_q, res_s_q, ovf_q, unf_q;
    logic [EXP_W-1:0]         res_e_q;
    logic [MAN_W-1:0]         res_m_q;
    logic                     xs_q, ys_q, sr_q;
    logic [EXP_W-1:0]         xe_q, ye_q;
    logic [MAN_W-1:0]         xm_q, ym_q;
    logic [EXP_W:0]           dmag_q;
    logic signed [EXP_W+1:0]  er_q;
    logic [MAN_W+1:0]         yw_q, mag_q;

    logic [EXP_W:0]           d_d, dmag_d;
    logic                     swap_d, neg_d, nz_d;
    logic [MAN_W+1:0]         yw_d, mag_d, xw_d;
    logic [MAN_W+2:0]         sum_d;
    logic [LZ_W-1:0]          lz_d;
    logic [MAN_W:0]           norm_d;
    logic [MAN_W-1:0]         nm_d;
    logic signed [EXP_W+1:0]  ne_d;

    // Exponent difference on EXP_W+1 bits; a negative difference means Y has the larger exponent.
    always_comb begin
        d_d    = {xe_q[EXP_W-1], xe_q} - {ye_q[EXP_W-1], ye_q};
        swap_d = d_d[EXP_W];
        dmag_d = swap_d ? ({(EXP_W+1){1'b0}} - d_d) : d_d;
    end

    // Alignment shift of the smaller operand into the carry/mantissa/guard word.
    always_comb begin
        yw_d = (dmag_q >= SH_LIM) ? {(MAN_W+2){1'b0}} : ({1'b0, ym_q, 1'b0} >> dmag_q);
    end

    // Magnitude add/subtract; a borrow out means Y > X, so negate and flip the sign.
    always_comb begin
        xw_d  = {1'b0, xm_q, 1'b0};
        sum_d = (xs_q == ys_q) ? ({1'b0, xw_d} + {1'b0, yw_q}) : ({1'b0, xw_d} - {1'b0, yw_q});
        neg_d = (xs_q != ys_q) && sum_d[MAN_W+2];
        if (neg_d) begin
            mag_d = ~sum_d[MAN_W+1:0] + {{(MAN_W+1){1'b0}}, 1'b1};
        end else begin
            mag_d = sum_d[MAN_W+1:0];
        end
    end

    // Normalisation: carry shifts right, otherwise shift left by leading-zero count (guard shifts in).
    always_comb begin
        lz_d = {LZ_W{1'b0}};
        for (int i = 0; i <= MAN_W; i++) begin
            lz_d = mag_q[i] ? LZ_W'(MAN_W - i) : lz_d;
        end
        nz_d = (mag_q == {(MAN_W+2){1'b0}});
        if (mag_q[MAN_W+1]) begin
            norm_d = mag_q[MAN_W+1:1];
            ne_d   = er_q + E_ONE;
        end else begin
            norm_d = mag_q[MAN_W:0] << lz_d;
            ne_d   = er_q - $signed({{(EXP_W+2-LZ_W){1'b0}}, lz_d});
        end
        nm_d = MAN_W'(norm_d >> 1);
    end

`ifdef FP_ADDSUB_ROUND_EN
    logic [MAN_W-1:0]        nm_q, rm_d;
    logic                    ng_q, nz_q;
    logic signed [EXP_W+1:0] ne_q, re_d;
    logic [MAN_W:0]          inc_d;

    // Ties-away rounding only needs the guard bit: any sticky bits cannot change the decision.
    always_comb begin
        inc_d = {1'b0, nm_q} + {{MAN_W{1'b0}}, ng_q};
        if (inc_d[MAN_W]) begin
            rm_d = {1'b1, {(MAN_W-1){1'b0}}};
            re_d = ne_q + E_ONE;
        end else begin
            rm_d = inc_d[MAN_W-1:0];
            re_d = ne_q;
        end
    end
`endif

    // Pipeline FSM with registered datapath and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idle_q      <= 1'b1;
            res_valid_q <= 1'b0;
            res_s_q     <= 1'b0;
            res_e_q     <= {EXP_W{1'b0}};
            res_m_q     <= {MAN_W{1'b0}};
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            xs_q        <= 1'b0;
            ys_q        <= 1'b0;
            sr_q        <= 1'b0;
            xe_q        <= {EXP_W{1'b0}};
            ye_q        <= {EXP_W{1'b0}};
            xm_q        <= {MAN_W{1'b0}};
            ym_q        <= {MAN_W{1'b0}};
            dmag_q      <= {(EXP_W+1){1'b0}};
            er_q        <= {(EXP_W+2){1'b0}};
            yw_q        <= {(MAN_W+2){1'b0}};
            mag_q       <= {(MAN_W+2){1'b0}};
`ifdef FP_ADDSUB_ROUND_EN
            nm_q        <= {MAN_W{1'b0}};
            ng_q        <= 1'b0;
            nz_q        <= 1'b0;
            ne_q        <= {(EXP_W+2){1'b0}};
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        xs_q    <= bus.a_s;
                        xe_q    <= (bus.a_m == {MAN_W{1'b0}}) ? E_ZERO : bus.a_e;
                        xm_q    <= bus.a_m;
                        ys_q    <= bus.b_s ^ bus.op_sub;
                        ye_q    <= (bus.b_m == {MAN_W{1'b0}}) ? E_ZERO : bus.b_e;
                        ym_q    <= bus.b_m;
                        idle_q  <= 1'b0;
                        state_q <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    dmag_q <= dmag_d;
                    if (swap_d) begin
                        xs_q <= ys_q;
                        ys_q <= xs_q;
                        xm_q <= ym_q;
                        ym_q <= xm_q;
                        sr_q <= ys_q;
                        er_q <= $signed({{2{ye_q[EXP_W-1]}}, ye_q});
                    end else begin
                        sr_q <= xs_q;
                        er_q <= $signed({{2{xe_q[EXP_W-1]}}, xe_q});
                    end
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    yw_q    <= yw_d;
                    state_q <= S_ADDSUB;
                end
                S_ADDSUB: begin
                    mag_q   <= mag_d;
                    sr_q    <= sr_q ^ neg_d;
                    state_q <= S_NORM;
                end
`ifdef FP_ADDSUB_ROUND_EN
                S_NORM: begin
                    nm_q    <= nm_d;
                    ng_q    <= norm_d[0];
                    nz_q    <= nz_d;
                    ne_q    <= ne_d;
                    state_q <= S_ROUND;
                end
                S_ROUND: begin
                    {ovf_q, unf_q, res_s_q, res_e_q, res_m_q} <= pack_result(sr_q, re_d, rm_d, nz_q);
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
`else
                S_NORM: begin
                    {ovf_q, unf_q, res_s_q, res_e_q, res_m_q} <= pack_result(sr_q, ne_d, nm_d, nz_d);
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
`endif
                S_DONE: begin
                    res_valid_q <= 1'b0;
                    idle_q      <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    res_valid_q <= 1'b0;
                    idle_q      <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.res_s     = res_s_q;
    assign bus.res_e     = res_e_q;
    assign bus.res_m     = res_m_q;
    assign bus.res_valid = res_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
    assign bus.idle      = idle_q;
endmodule
